dot_product_result_requant: RTL and testbench

- Downstream stage for dot_product_16_8x8: consumes its 48-bit signed o_sum/o_valid result stream.
- Requantizes each result to a W-bit signed value: round-half-up, then arithmetic right shift by a runtime amount, then saturate.
- Buffers results in a first-word-fall-through FIFO with a valid/ready output, so a stalling consumer does not lose results from the non-stallable dot-product pipeline.
- Reports backpressure early (o_afull) and records drops and saturations.

---
 rtl/dot_product_result_requant.sv | 164 ++++++++++++++++
 tb/tb_dot_product_result_requant.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_result_requant.sv
// Requantizes the 48-bit dot-product result stream to W-bit signed values and buffers them
// in a first-word-fall-through FIFO so a stalling consumer does not lose results.
module dot_product_result_requant #(
    parameter int unsigned S           = 48,
    parameter int unsigned W           = 16,
    parameter int unsigned SH          = 6,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AFULL_LEVEL = 12
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [S-1:0]        i_sum,
    input  logic                i_valid,
    input  logic [SH-1:0]       i_shift,
    input  logic                i_clear,
    output logic signed [W-1:0] o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_afull,
    output logic                o_overflow,
    output logic [15:0]         o_sat_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [SH-1:0]     ShMax    = SH'(S - 1);
    localparam logic [CW-1:0]     FullCnt  = CW'(DEPTH);
    localparam logic [CW-1:0]     AfullCnt = CW'(AFULL_LEVEL);
    localparam logic signed [S:0] QMax     = {{(S + 2 - W){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [S:0] QMin     = {{(S + 2 - W){1'b1}}, {(W - 1){1'b0}}};
    localparam logic signed [S:0] One      = {{S{1'b0}}, 1'b1};

    // Stage 1: clamp shift, add the rounding half-LSB in S+1 bits so it never wraps
    logic [SH-1:0]     sh_c;
    logic signed [S:0] rnd_c;
    logic signed [S:0] t_c;

    always_comb begin
        sh_c  = (i_shift > ShMax) ? ShMax : i_shift;
        rnd_c = '0;
        if (sh_c != '0) begin
            rnd_c = One <<< (sh_c - SH'(1));
        end
        t_c = $signed({i_sum[S-1], i_sum}) + rnd_c;
    end

    logic              s1_valid_q;
    logic signed [S:0] s1_t_q;
    logic [SH-1:0]     s1_sh_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid_q <= 1'b0;
            s1_t_q     <= '0;
            s1_sh_q    <= '0;
        end else begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_t_q  <= t_c;
                s1_sh_q <= sh_c;
            end
        end
    end

    // Stage 2: arithmetic shift and saturate to W bits
    logic signed [S:0]   q_c;
    logic signed [W-1:0] out_c;
    logic                sat_c;

    always_comb begin
        q_c = s1_t_q >>> s1_sh_q;
        if (q_c > QMax) begin
            out_c = QMax[W-1:0];
            sat_c = 1'b1;
        end else if (q_c < QMin) begin
            out_c = QMin[W-1:0];
            sat_c = 1'b1;
        end else begin
            out_c = q_c[W-1:0];
            sat_c = 1'b0;
        end
    end

    logic                s2_valid_q;
    logic signed [W-1:0] s2_data_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= out_c;
            end
        end
    end

    // Stage 3: FWFT FIFO; occupancy counter spans 0..DEPTH so full and empty never alias
    logic signed [W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic                pop;
    logic                push_ok;
    logic                drop;
    logic                sat_evt;

    always_comb begin
        pop     = (count_q != '0) && i_ready;
        push_ok = s2_valid_q && ((count_q != FullCnt) || pop);
        drop    = s2_valid_q && (count_q == FullCnt) && !pop;
        sat_evt = s1_valid_q && sat_c;
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= s2_data_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            o_afull     <= 1'b0;
            o_overflow  <= 1'b0;
            o_sat_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            o_afull <= (count_d >= AfullCnt);
            // Clear takes priority over a coinciding drop or saturation
            if (i_clear) begin
                o_overflow  <= 1'b0;
                o_sat_count <= '0;
            end else begin
                if (drop) begin
                    o_overflow <= 1'b1;
                end
                if (sat_evt && (o_sat_count != 16'hFFFF)) begin
                    o_sat_count <= o_sat_count + 16'd1;
                end
            end
        end
    end

    assign o_valid = (count_q != '0);
    assign o_data  = o_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_dot_product_result_requant.sv
// Bench for dot_product_result_requant: directed scenarios plus a randomized run checked
// against a queue-based reference model.
module tb_dot_product_result_requant;

    localparam int S  = 48;
    localparam int W  = 16;
    localparam int SH = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [S-1:0]        i_sum = '0;
    logic                i_valid = 1'b0;
    logic [SH-1:0]       i_shift = '0;
    logic                i_clear = 1'b0;
    logic signed [W-1:0] o_data;
    logic                o_valid;
    logic                i_ready = 1'b0;
    logic                o_afull;
    logic                o_overflow;
    logic [15:0]         o_sat_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dot_product_result_requant dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_sum      (i_sum),
        .i_valid    (i_valid),
        .i_shift    (i_shift),
        .i_clear    (i_clear),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_afull    (o_afull),
        .o_overflow (o_overflow),
        .o_sat_count(o_sat_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference requantization: round half up, floor-shift, clip to signed W bits.
    function automatic void requant(input longint sum, input int shift,
                                    output longint res, output bit sat);
        int     sh;
        longint t;
        longint q;
        sh  = (shift > S - 1) ? S - 1 : shift;
        t   = sum + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : 0);
        q   = t >>> sh;
        sat = 1'b0;
        res = q;
        if (q > 32767) begin
            res = 32767;
            sat = 1'b1;
        end else if (q < -32768) begin
            res = -32768;
            sat = 1'b1;
        end
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_data !== 16'sd0 || o_afull !== 1'b0 ||
            o_overflow !== 1'b0 || o_sat_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%0d af=%b ov=%b sc=%0d, expected all zero",
                     o_valid, o_data, o_afull, o_overflow, o_sat_count);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_data !== 16'sd0 || o_afull !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got v=%b d=%0d af=%b, expected 0 0 0",
                     o_valid, o_data, o_afull);
        end
    endtask

    task automatic test_latency();
        i_ready = 1'b1;
        i_shift = '0;
        i_sum   = S'(100);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_e0: got o_valid=%b expected 0", o_valid);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_e1: got o_valid=%b expected 0", o_valid);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 16'sd100) begin
            errors++;
            $display("FAIL latency_e2: got v=%b d=%0d expected v=1 d=100", o_valid, o_data);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_sat_count !== 16'd0) begin
            errors++;
            $display("FAIL latency_pop: got v=%b sc=%0d expected v=0 sc=0", o_valid, o_sat_count);
        end
    endtask

    task automatic test_rounding();
        longint sums [5] = '{40, -40, 24, -24, 1};
        int     shs  [5] = '{4, 4, 4, 4, 63};
        int     exps [5] = '{3, -2, 2, -1, 0};
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_sum   = S'(sums[i]);
            i_shift = SH'(shs[i]);
            i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        tick();
        tick();
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== W'(exps[i])) begin
                errors++;
                $display("FAIL rounding_%0d: got v=%b d=%0d expected v=1 d=%0d",
                         i, o_valid, o_data, exps[i]);
            end
            tick();
        end
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rounding_empty: got o_valid=%b expected 0", o_valid);
        end
    endtask

    task automatic test_saturation();
        longint sums [4] = '{40000, -40000, 32767, -32768};
        int     exps [4] = '{32767, -32768, 32767, -32768};
        i_ready = 1'b0;
        i_shift = '0;
        for (int i = 0; i < 4; i++) begin
            i_sum   = S'(sums[i]);
            i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        tick();
        tick();
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== W'(exps[i])) begin
                errors++;
                $display("FAIL saturation_%0d: got v=%b d=%0d expected v=1 d=%0d",
                         i, o_valid, o_data, exps[i]);
            end
            tick();
        end
        checks++;
        if (o_sat_count !== 16'd2) begin
            errors++;
            $display("FAIL sat_count: got %0d expected 2", o_sat_count);
        end
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        checks++;
        if (o_sat_count !== 16'd0) begin
            errors++;
            $display("FAIL sat_clear: got %0d expected 0", o_sat_count);
        end
    endtask

    task automatic test_overflow();
        int cnt;
        i_ready = 1'b0;
        i_shift = '0;
        for (int e = 1; e <= 19; e++) begin
            i_valid = (e <= 17);
            i_sum   = S'(e);
            tick();
            cnt = (e - 2 < 0) ? 0 : ((e - 2 > 16) ? 16 : e - 2);
            checks++;
            if (o_afull !== (cnt >= 12) || o_valid !== (cnt > 0) ||
                o_overflow !== (e >= 19)) begin
                errors++;
                $display("FAIL fill_edge%0d: got af=%b v=%b ov=%b expected af=%b v=%b ov=%b",
                         e, o_afull, o_valid, o_overflow, cnt >= 12, cnt > 0, e >= 19);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== W'(k + 1) || o_afull !== ((16 - k) >= 12)) begin
                errors++;
                $display("FAIL drain_%0d: got v=%b d=%0d af=%b expected v=1 d=%0d af=%b",
                         k, o_valid, o_data, o_afull, k + 1, (16 - k) >= 12);
            end
            tick();
        end
        checks++;
        if (o_valid !== 1'b0 || o_afull !== 1'b0 || o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL drain_end: got v=%b af=%b ov=%b expected 0 0 1",
                     o_valid, o_afull, o_overflow);
        end
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got %b expected 0", o_overflow);
        end
    endtask

    task automatic test_full_pop();
        i_ready = 1'b0;
        i_shift = '0;
        for (int v = 1; v <= 16; v++) begin
            i_sum   = S'(v);
            i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        tick();
        tick();
        i_sum   = S'(99);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        checks++;
        if (o_overflow !== 1'b0 || o_valid !== 1'b1 || o_data !== 16'sd2 || o_afull !== 1'b1) begin
            errors++;
            $display("FAIL full_pop: got ov=%b v=%b d=%0d af=%b expected ov=0 v=1 d=2 af=1",
                     o_overflow, o_valid, o_data, o_afull);
        end
        i_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== W'((k < 15) ? k + 2 : 99)) begin
                errors++;
                $display("FAIL full_pop_drain_%0d: got v=%b d=%0d expected v=1 d=%0d",
                         k, o_valid, o_data, (k < 15) ? k + 2 : 99);
            end
            tick();
        end
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_empty: got o_valid=%b expected 0", o_valid);
        end
    endtask

    task automatic test_reset_midstream();
        i_ready = 1'b0;
        i_shift = '0;
        for (int v = 1; v <= 7; v++) begin
            i_sum   = S'(v);
            i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_data !== 16'sd1) begin
            errors++;
            $display("FAIL pre_reset: got v=%b d=%0d expected v=1 d=1", o_valid, o_data);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_data !== 16'sd0 || o_afull !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%0d af=%b expected 0 0 0",
                     o_valid, o_data, o_afull);
        end
        tick();
        tick();
        rst     = 1'b0;
        i_sum   = S'(7);
        i_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 16'sd7) begin
            errors++;
            $display("FAIL post_reset: got v=%b d=%0d expected v=1 d=7", o_valid, o_data);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_%0d: got o_valid=%b expected 0", k, o_valid);
            end
        end
    endtask

    task automatic test_random();
        longint      fq[$];
        bit          s1_v, s2_v, s1_sat;
        longint      s1_d, s2_d;
        int unsigned sat_m;
        bit          ovf_m;
        longint      sum;
        longint      head;
        longint      res;
        bit          sat;
        bit          pop, full, drop;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        s1_v = 0; s2_v = 0; s1_sat = 0; s1_d = 0; s2_d = 0;
        sat_m = 0; ovf_m = 0;
        for (int c = 0; c < 600; c++) begin
            head = (fq.size() > 0) ? fq[0] : 0;
            checks++;
            if (o_valid !== (fq.size() > 0) || o_data !== W'(head) ||
                o_afull !== (fq.size() >= 12) || o_overflow !== ovf_m ||
                o_sat_count !== 16'(sat_m)) begin
                errors++;
                $display("FAIL random_c%0d: got v=%b d=%0d af=%b ov=%b sc=%0d expected v=%b d=%0d af=%b ov=%b sc=%0d",
                         c, o_valid, o_data, o_afull, o_overflow, o_sat_count,
                         fq.size() > 0, head, fq.size() >= 12, ovf_m, sat_m);
            end
            case ($urandom_range(0, 2))
                0: sum = longint'($urandom_range(0, 200000)) - 100000;
                1: sum = longint'({$urandom, $urandom});
                default: sum = longint'(signed'($urandom));
            endcase
            sum     = (sum <<< 16) >>> 16;
            i_sum   = sum[S-1:0];
            i_shift = SH'($urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : $urandom_range(0, 20));
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 9) < ((c / 100) % 2 == 0 ? 3 : 8));
            i_clear = ($urandom_range(0, 29) == 0);
            pop  = (fq.size() > 0) && i_ready;
            full = (fq.size() == 16);
            drop = 0;
            if (pop) void'(fq.pop_front());
            if (s2_v) begin
                if (full && !pop) drop = 1;
                else fq.push_back(s2_d);
            end
            if (i_clear) begin
                sat_m = 0;
                ovf_m = 0;
            end else begin
                if (s1_v && s1_sat && sat_m != 65535) sat_m++;
                if (drop) ovf_m = 1;
            end
            s2_v = s1_v;
            s2_d = s1_d;
            requant(sum, int'(i_shift), res, sat);
            s1_v   = i_valid;
            s1_d   = res;
            s1_sat = sat;
            tick();
        end
        i_valid = 1'b0;
        i_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rounding();
        test_saturation();
        test_overflow();
        test_full_pop();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
